// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Single-outstanding instruction fetch stage. The unit requests the word at
//   PC, waits for memory to return it, and holds it for the decoder until
//   downstream accepts it. On acceptance the PC advances to PC+4 or to a
//   branch/jump target. A misaligned taken target parks the unit in a sticky
//   fault state that only reset can clear.
//
// Ports
//   clk          : clock; all state updates on the rising edge
//   rst          : synchronous active-low reset
//   PCSrc        : take PCTarget as next PC (sampled only on acceptance)
//   PCTarget     : branch/jump target address
//   instr_ready  : downstream accepts the held instruction this cycle
//   imem_req     : instruction-memory read request
//   imem_addr    : read address (always PC)
//   imem_ready   : memory returns imem_rdata this cycle
//   imem_rdata   : returned instruction word
//   Instr        : registered instruction
//   Op/funct3/funct7 : decode fields of Instr
//   PC, PCPlus4  : address of Instr and PC+4
//   instr_valid  : Instr holds a fetched, unconsumed instruction
//   fetch_fault  : sticky misaligned-target error
//   retired_cnt  : count of accepted instructions (wraps silently)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        instr_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [6:0]  Op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic [31:0] retired_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [31:0] r_retired;
  logic [31:0] w_retired_nxt;
  logic        r_fault;
  logic        w_fault_nxt;
  logic [31:0] w_pc_plus4;

  // Natural 32-bit overflow gives the required modulo-2^32 wrap.
  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_instr_nxt   = r_instr;
    w_retired_nxt = r_retired;
    w_fault_nxt   = r_fault;
    case (r_state)
      FETCH: begin
        if (imem_ready) begin
          w_instr_nxt = imem_rdata;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          w_retired_nxt = r_retired + 32'd1;
          // A misaligned taken target still retires the instruction but
          // keeps PC pointing at it so the faulting address is visible.
          if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = FAULT;
          end else begin
            w_pc_nxt    = PCSrc ? PCTarget : w_pc_plus4;
            w_state_nxt = FETCH;
          end
        end
      end
      FAULT: begin
        w_state_nxt = FAULT;
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_instr   <= NOP;
      r_fault   <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_fault   <= w_fault_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  // All handshake and decode outputs come straight from registers.
  assign imem_req    = (r_state == FETCH);
  assign instr_valid = (r_state == ISSUE);
  assign imem_addr   = r_pc;
  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign Instr       = r_instr;
  assign Op          = r_instr[6:0];
  assign funct3      = r_instr[14:12];
  assign funct7      = r_instr[31:25];
  assign fetch_fault = r_fault;
  assign retired_cnt = r_retired;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. Stimulus pushes the expected fetch
//   address and accepted (PC, Instr) pairs into queues; a negedge monitor pops
//   and compares whenever the DUT issues a fetch handshake or an acceptance.
//   A second instance with RESET_PC = FFFF_FFFC covers PC wrap.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A (RESET_PC = 0)
  logic        PCSrc, instr_ready, imem_ready;
  logic [31:0] PCTarget, imem_rdata;
  logic        imem_req, instr_valid, fetch_fault;
  logic [31:0] imem_addr, Instr, PC, PCPlus4, retired_cnt;
  logic [6:0]  Op, funct7;
  logic [2:0]  funct3;

  // Instance B (RESET_PC = FFFF_FFFC)
  logic        b_PCSrc, b_instr_ready, b_imem_ready;
  logic [31:0] b_PCTarget, b_imem_rdata;
  logic        b_imem_req, b_instr_valid, b_fetch_fault;
  logic [31:0] b_imem_addr, b_Instr, b_PC, b_PCPlus4, b_retired_cnt;
  logic [6:0]  b_Op, b_funct7;
  logic [2:0]  b_funct3;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .instr_ready(instr_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .Instr(Instr),
    .Op(Op), .funct3(funct3), .funct7(funct7), .PC(PC), .PCPlus4(PCPlus4),
    .instr_valid(instr_valid), .fetch_fault(fetch_fault),
    .retired_cnt(retired_cnt)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst), .PCSrc(b_PCSrc), .PCTarget(b_PCTarget),
    .instr_ready(b_instr_ready), .imem_req(b_imem_req),
    .imem_addr(b_imem_addr), .imem_ready(b_imem_ready),
    .imem_rdata(b_imem_rdata), .Instr(b_Instr), .Op(b_Op),
    .funct3(b_funct3), .funct7(b_funct7), .PC(b_PC), .PCPlus4(b_PCPlus4),
    .instr_valid(b_instr_valid), .fetch_fault(b_fetch_fault),
    .retired_cnt(b_retired_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } acc_t;

  logic [31:0] q_fetch[$];
  acc_t        q_acc[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_txn(input logic [31:0] pc, input logic [31:0] instr);
    acc_t a;
    a.pc    = pc;
    a.instr = instr;
    q_fetch.push_back(pc);
    q_acc.push_back(a);
  endtask

  // Scoreboard monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (imem_req && imem_ready) begin
        if (q_fetch.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
        end else begin
          chk("fetch_addr", imem_addr, q_fetch.pop_front());
        end
      end
      if (instr_valid && instr_ready) begin
        if (q_acc.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL accept_unexpected: got pc %h expected no accept", PC);
        end else begin
          acc_t e;
          e = q_acc.pop_front();
          chk("acc_pc", PC, e.pc);
          chk("acc_instr", Instr, e.instr);
          chk("acc_op", {25'd0, Op}, {25'd0, e.instr[6:0]});
          chk("acc_funct3", {29'd0, funct3}, {29'd0, e.instr[14:12]});
          chk("acc_funct7", {25'd0, funct7}, {25'd0, e.instr[31:25]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    PCSrc = 1'b0; PCTarget = '0; instr_ready = 1'b0;
    imem_ready = 1'b0; imem_rdata = '0;
    b_PCSrc = 1'b0; b_PCTarget = '0; b_instr_ready = 1'b0;
    b_imem_ready = 1'b0; b_imem_rdata = '0;

    // Reset state
    step();
    chk("rst_req", imem_req, 1'b1);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", Instr, 32'h0000_0013);
    chk("rst_fault", fetch_fault, 1'b0);
    chk("rst_cnt", retired_cnt, 32'h0);
    chk("b_rst_pc", b_PC, 32'hFFFF_FFFC);
    chk("b_rst_addr", b_imem_addr, 32'hFFFF_FFFC);
    chk("b_pcplus4_wrap", b_PCPlus4, 32'h0);
    rst = 1'b1;

    // PC wrap on instance B
    b_imem_ready = 1'b1; b_imem_rdata = 32'h0050_0093; b_instr_ready = 1'b1;
    step();
    chk("b_valid", b_instr_valid, 1'b1);
    chk("b_instr", b_Instr, 32'h0050_0093);
    b_imem_ready = 1'b0;
    step();
    chk("b_pc_wrap", b_PC, 32'h0);
    chk("b_cnt", b_retired_cnt, 32'd1);
    chk("b_req", b_imem_req, 1'b1);
    chk("b_pcplus4", b_PCPlus4, 32'd4);
    b_instr_ready = 1'b0;

    // Basic fetch and accept
    expect_txn(32'h0, 32'h0050_0093);
    imem_ready = 1'b1; imem_rdata = 32'h0050_0093; instr_ready = 1'b1;
    step();
    chk("t1_valid", instr_valid, 1'b1);
    chk("t1_op", {25'd0, Op}, 32'h13);
    chk("t1_req", imem_req, 1'b0);
    imem_ready = 1'b0;
    step();
    chk("t1_pc", PC, 32'd4);
    chk("t1_cnt", retired_cnt, 32'd1);
    chk("t1_req_next", imem_req, 1'b1);
    instr_ready = 1'b0;

    // Memory wait states
    for (int i = 0; i < 5; i++) begin
      chk("wait_req", imem_req, 1'b1);
      chk("wait_addr", imem_addr, 32'd4);
      chk("wait_valid", instr_valid, 1'b0);
      step();
    end
    expect_txn(32'd4, 32'h4020_8133);
    imem_ready = 1'b1; imem_rdata = 32'h4020_8133;
    step();
    chk("wait_capture", instr_valid, 1'b1);
    chk("t2_funct7", {25'd0, funct7}, 32'h20);

    // Stall in ISSUE; PCSrc and stray imem_ready ignored
    imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      PCSrc = (i % 2 == 0); PCTarget = 32'h200 + 32'(i * 4);
      step();
      chk("stall_instr", Instr, 32'h4020_8133);
      chk("stall_pc", PC, 32'd4);
      chk("stall_valid", instr_valid, 1'b1);
    end
    imem_ready = 1'b0;
    PCSrc = 1'b1; PCTarget = 32'h100; instr_ready = 1'b1;
    step();
    chk("branch_addr", imem_addr, 32'h100);
    chk("branch_req", imem_req, 1'b1);
    chk("branch_cnt", retired_cnt, 32'd2);
    PCSrc = 1'b0; instr_ready = 1'b0;

    // PCSrc asserted during FETCH is ignored
    expect_txn(32'h100, 32'h0000_A183);
    imem_ready = 1'b1; imem_rdata = 32'h0000_A183;
    PCSrc = 1'b1; PCTarget = 32'h300;
    step();
    chk("lw_op", {25'd0, Op}, 32'h03);
    chk("lw_funct3", {29'd0, funct3}, 32'h2);
    imem_ready = 1'b0; PCSrc = 1'b0; instr_ready = 1'b1;
    step();
    chk("seq_pc", PC, 32'h104);
    chk("seq_cnt", retired_cnt, 32'd3);
    instr_ready = 1'b0;

    // Misaligned target -> sticky fault
    expect_txn(32'h104, 32'h0010_0073);
    imem_ready = 1'b1; imem_rdata = 32'h0010_0073;
    step();
    imem_ready = 1'b0;
    PCSrc = 1'b1; PCTarget = 32'h102; instr_ready = 1'b1;
    step();
    chk("fault_flag", fetch_fault, 1'b1);
    chk("fault_req", imem_req, 1'b0);
    chk("fault_valid", instr_valid, 1'b0);
    chk("fault_pc", PC, 32'h104);
    chk("fault_cnt", retired_cnt, 32'd4);
    PCSrc = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frozen_pc", PC, 32'h104);
      chk("frozen_instr", Instr, 32'h0010_0073);
      chk("frozen_cnt", retired_cnt, 32'd4);
      chk("frozen_fault", fetch_fault, 1'b1);
      chk("frozen_req", imem_req, 1'b0);
    end
    rst = 1'b0;
    step();
    chk("clr_fault", fetch_fault, 1'b0);
    chk("clr_pc", PC, 32'h0);
    chk("clr_req", imem_req, 1'b1);
    chk("clr_addr", imem_addr, 32'h0);
    chk("clr_instr", Instr, 32'h0000_0013);
    chk("clr_cnt", retired_cnt, 32'h0);
    rst = 1'b1; imem_ready = 1'b0; instr_ready = 1'b0;

    // Reset beats imem_ready in FETCH
    expect_txn(32'h0, 32'h0000_0013);
    imem_ready = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_ready = 1'b0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("pre_rst_pc", PC, 32'd4);
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("rstf_instr", Instr, 32'h0000_0013);
    chk("rstf_valid", instr_valid, 1'b0);
    chk("rstf_pc", PC, 32'h0);
    chk("rstf_req", imem_req, 1'b1);
    rst = 1'b1; imem_ready = 1'b0;

    // Reset abandons an instruction in ISSUE
    q_fetch.push_back(32'h0);
    imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_ready = 1'b0;
    chk("rsti_valid_pre", instr_valid, 1'b1);
    rst = 1'b0; instr_ready = 1'b1; PCSrc = 1'b1; PCTarget = 32'h200;
    step();
    chk("rsti_pc", PC, 32'h0);
    chk("rsti_req", imem_req, 1'b1);
    chk("rsti_valid", instr_valid, 1'b0);
    chk("rsti_cnt", retired_cnt, 32'h0);
    rst = 1'b1; instr_ready = 1'b0; PCSrc = 1'b0;

    // retired_cnt wrap from preset all-ones
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    expect_txn(32'h0, 32'h0000_0013);
    imem_ready = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_ready = 1'b0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("cnt_wrap", retired_cnt, 32'h0);
    chk("wrap_pc", PC, 32'd4);

    step();
    chk("q_fetch_empty", q_fetch.size(), 32'd0);
    chk("q_acc_empty", q_acc.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port PCSrc, input, 1: select PCTarget as the next PC (taken branch/jump).
REQ-005 SHALL have port PCTarget, input, 32: branch/jump target address.
REQ-006 SHALL have port instr_ready, input, 1: downstream accepts the current instruction this cycle.
REQ-007 SHALL have port imem_req, output, 1: instruction-memory read request.
REQ-008 SHALL have port imem_addr, output, 32: read address; always equal to PC.
REQ-009 SHALL have port imem_ready, input, 1: memory returns imem_rdata this cycle.
REQ-010 SHALL have port imem_rdata, input, 32: returned instruction word.
REQ-011 SHALL have port Instr, output, 32: registered instruction.
REQ-012 SHALL have port Op, output, 7: Instr[6:0]; funct3, output, 3: Instr[14:12]; funct7, output, 7: Instr[31:25]. These drive the control-unit decode inputs.
REQ-013 SHALL have port PC, output, 32: address of Instr; PCPlus4, output, 32: PC+4.
REQ-014 SHALL have port instr_valid, output, 1: Instr holds a fetched, unconsumed instruction.
REQ-015 SHALL have port fetch_fault, output, 1: sticky misaligned-target error.
REQ-016 SHALL have port retired_cnt, output, 32: count of accepted instructions.

Function
REQ-017 SHALL implement three states: FETCH, ISSUE, and FAULT.
REQ-018 FETCH: imem_req=1 and instr_valid=0; when imem_ready=1, Instr<=imem_rdata and next state is ISSUE; otherwise the unit stays in FETCH with no limit on wait cycles.
REQ-019 ISSUE: imem_req=0 and instr_valid=1; Instr and PC SHALL be held stable until instr_ready=1.
REQ-020 ISSUE with instr_ready=1: retired_cnt increments; next PC is PCTarget if PCSrc=1, else PC+4; next state is FETCH.
REQ-021 PCSrc and PCTarget SHALL be sampled only in ISSUE with instr_ready=1 and ignored otherwise.
REQ-022 If PCSrc=1 and PCTarget[1:0]!=2'b00 at acceptance: PC is held, fetch_fault<=1, and next state is FAULT; retired_cnt still increments.
REQ-023 FAULT: imem_req=0, instr_valid=0, all registers frozen; exit only by reset.
REQ-024 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); PCPlus4 SHALL be combinational PC+32'd4.
REQ-025 retired_cnt SHALL wrap from 32'hFFFF_FFFF to 0 with no flag.
REQ-026 imem_ready asserted outside FETCH SHALL be ignored.
REQ-027 Latency: at least 1 cycle from FETCH entry to instr_valid; 1 cycle from acceptance to the next imem_req.
REQ-028 imem_req, instr_valid, imem_addr, Op, funct3, and funct7 SHALL be decoded directly from registers, with no combinational path from any input.

Reset
REQ-029 On a rising clk edge with rst=0: state<=FETCH, PC<=RESET_PC, Instr<=32'h0000_0013 (NOP), fetch_fault<=0, retired_cnt<=0.
REQ-030 Reset SHALL take priority over all other events, including imem_ready, instr_ready, and FAULT.
REQ-031 Reset asserted mid-FETCH or mid-ISSUE SHALL abandon the transaction; imem_req=1 with imem_addr=RESET_PC in the first cycle after release.
REQ-032 Outputs while rst=0 and before the first edge are undefined; the bench checks from the first reset edge onward.

Verification
REQ-033 Reset, then imem_ready=1 with imem_rdata=32'h00500093 and instr_ready=1 -> imem_addr=0 → Instr=32'h00500093, Op=7'h13, instr_valid=1, then PC=4 and retired_cnt=1.
REQ-034 imem_ready held low for 5 cycles in FETCH -> imem_req stays 1, imem_addr stays constant, instr_valid=0 throughout; capture on the 6th cycle.
REQ-035 ISSUE with instr_ready=0 for 3 cycles, PCSrc=1 toggling -> Instr and PC unchanged; on accept with PCSrc=1 and PCTarget=32'h100, the next imem_addr=32'h100.
REQ-036 Accept with PCSrc=1 and PCTarget=32'h102 -> fetch_fault=1, state FAULT, imem_req=0, PC unchanged; rst=0 for one edge clears the fault and refetches RESET_PC.
REQ-037 RESET_PC=32'hFFFF_FFFC, accept with PCSrc=0 -> PC=0; retired_cnt preset via 2^32 accepts (or force) wraps to 0.
REQ-038 rst=0 asserted in the same cycle as imem_ready=1 in FETCH -> Instr=32'h00000013, instr_valid=0, PC=RESET_PC.
